mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Parametrised CPU memory-bus decoder/multiplexer between the picorv32 native memory port and NUM_SLV memory-mapped slaves (ROM, RAM, MMIO cores).
- Replaces the fixed, hand-written area/core case decode with a prefix/mask table.
- Adds an explicit access FSM, a per-access ready timeout and a sticky bus-error capture register.
- Sits in the top level; slave side is flattened vectors.

Parameters:
- NUM_SLV, 8, number of slave ports (1..16).
- SLV_PREFIX, {NUM_SLV{8'h00}}, 8 bits per slave; compared against cpu_addr[31:24]; slave i uses bits [8i+7:8i].
- SLV_MASK, {NUM_SLV{8'hff}}, 8 bits per slave; a 1 means the bit takes part in the compare. A ROM/RAM area entry uses 8'hc0.
- ADDR_W, 15, word-address width driven to slaves: slv_address = cpu_addr[ADDR_W+1:2].
- TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before forced completion; 8-bit counter; 0 disables timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_valid  in  1  picorv32 mem_valid.
- cpu_wstrb  in  4  byte write strobes; 0 means read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  registered read data.
- cpu_ready  out  1  registered one-cycle completion pulse.
- slv_cs  out  NUM_SLV  one-hot chip select.
- slv_we  out  4  copy of cpu_wstrb; slaves OR-reduce it if needed.
- slv_address  out  ADDR_W  shared word address.
- slv_write_data  out  32  shared write data.
- slv_read_data  in  NUM_SLV*32  per-slave read data; slave i at [32i+31:32i].
- slv_ready  in  NUM_SLV  per-slave ready.
- err_clear  in  1  single-cycle clear of the error capture.
- bus_error  out  1  sticky error flag.
- err_addr  out  32  cpu_addr of the first erroring access since the last clear.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; cpu_ready=0, cpu_rdata=0, bus_error=0, err_addr=0, timeout counter=0.
  - slv_cs=0 combinationally.
- Decode: hit[i] = ((cpu_addr[31:24] ^ SLV_PREFIX[i]) & SLV_MASK[i]) == 0. The lowest-index hit wins. No hit is a decode error.
- FSM states IDLE, ACCESS, RESP.
  - IDLE with cpu_valid=1:
    - On a hit, slv_cs[sel]=1 combinationally in the same cycle.
    - If slv_ready[sel]=1 that cycle: capture slv_read_data[sel] into cpu_rdata and go to RESP. Otherwise latch sel, clear the counter and go to ACCESS.
    - On a miss: cpu_rdata<=0, set the error, go to RESP.
  - ACCESS:
    - slv_cs[sel_reg]=1; counter increments each cycle.
    - slv_ready[sel_reg]=1: capture data, go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 without ready: cpu_rdata<=0, set the error, go to RESP.
    - cpu_valid drops: abort to IDLE, no cpu_ready, no error.
  - RESP: cpu_ready=1 for exactly this cycle, slv_cs=0, then unconditionally go to IDLE.
- Latency:
  - Zero-wait slave: valid in cycle 0, cpu_ready in cycle 1.
  - Slave asserting ready in cycle n of ACCESS: cpu_ready in cycle n+1.
  - Next access is accepted in IDLE, two cycles after the previous start at minimum.
- slv_address, slv_write_data and slv_we are continuous copies of the CPU bus; they are valid only while slv_cs is set.
- Error capture:
  - On error, if bus_error=0, err_addr<=cpu_addr; bus_error<=1. Later errors do not overwrite err_addr.
  - err_clear zeroes bus_error and err_addr. A new error in the same cycle wins, so the capture is set.
- Only one slv_cs bit is ever high. A slv_ready from a non-selected slave is ignored.

Optional Feature:
- Macro MEM_BUS_APP_FENCE_EN.
- Enabled:
  - Adds input port fw_app_mode (1 bit) and parameter FENCE_MASK (NUM_SLV bits, default 0).
  - When fw_app_mode=1 and FENCE_MASK[sel]=1, the access is treated as a decode error: no slv_cs, cpu_rdata=0, error captured, cpu_ready in cycle 1.
- Disabled: no port, no parameter; all decoded accesses proceed.

Decomposition:
- Package mem_bus_pkg:
  - FSM state encoding.
  - Area prefix constants (ROM=2'h0, RAM=2'h1, RESERVED=2'h2, MMIO=2'h3).
  - Core prefix constants (TRNG 6'h00, TIMER 6'h01, UDS 6'h02, UART 6'h03, TOUCH_SENSE 6'h04, TK1 6'h3f).
  - Default timeout constant.
- One natural sub-module, mem_bus_decode: purely combinational prefix/mask match plus priority encoder outputting sel and hit.

Test Plan:
- Zero-wait read, slave 2 at prefix 8'hc2 with rdata 32'h1234_5678 and ready immediately: slv_cs=3'b100 in cycle 0; cpu_ready=1 and cpu_rdata=32'h1234_5678 in cycle 1; cpu_ready=0 in cycle 2.
- Wait-state write, wstrb=4'hf to a slave asserting ready on the 3rd ACCESS cycle: slv_cs held 4 cycles; single cpu_ready pulse; bus_error=0.
- Unmapped address 32'hc500_0000 with no match: cpu_ready in cycle 1, cpu_rdata=0, bus_error=1, err_addr=32'hc500_0000. A second miss at 32'h8000_0000 leaves err_addr unchanged. err_clear zeroes both.
- Timeout with TIMEOUT_CYCLES=4 and slave never ready: cpu_ready in cycle 5, rdata 0, bus_error=1.
- Overlap: prefixes 8'h40/mask 8'hc0 (index 1) and 8'h41/mask 8'hff (index 3), access 32'h4100_0000: only slv_cs[1] asserted.
- Reset asserted mid-ACCESS: slv_cs=0 and cpu_ready=0 immediately (async). After release, FSM is IDLE and a new access completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory-bus controller: FSM encoding,
// memory-map area/core prefix constants and small prefix helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Area prefix lives in cpu_addr[31:30]; core prefix in cpu_addr[29:24].
  localparam logic [1:0] AREA_ROM      = 2'h0;
  localparam logic [1:0] AREA_RAM      = 2'h1;
  localparam logic [1:0] AREA_RESERVED = 2'h2;
  localparam logic [1:0] AREA_MMIO     = 2'h3;

  localparam logic [5:0] CORE_TRNG        = 6'h00;
  localparam logic [5:0] CORE_TIMER       = 6'h01;
  localparam logic [5:0] CORE_UDS         = 6'h02;
  localparam logic [5:0] CORE_UART        = 6'h03;
  localparam logic [5:0] CORE_TOUCH_SENSE = 6'h04;
  localparam logic [5:0] CORE_TK1         = 6'h3f;

  localparam logic [7:0] AREA_MASK = 8'hc0;
  localparam logic [7:0] CORE_MASK = 8'hff;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic [7:0] area_prefix(input logic [1:0] area);
    return {area, 6'h00};
  endfunction

  function automatic logic [7:0] core_prefix(input logic [5:0] core);
    return {AREA_MMIO, core};
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational prefix/mask address decoder with lowest-index-wins priority.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int                   NUM_SLV    = 8,
  parameter int                   SEL_W      = 3,
  parameter logic [8*NUM_SLV-1:0] SLV_PREFIX = {NUM_SLV{8'h00}},
  parameter logic [8*NUM_SLV-1:0] SLV_MASK   = {NUM_SLV{8'hff}}
) (
  input  logic [7:0]       addr_hi,
  output logic [SEL_W-1:0] sel,
  output logic             hit
);

  logic [NUM_SLV-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      match[i] = ((addr_hi ^ SLV_PREFIX[8*i +: 8]) & SLV_MASK[8*i +: 8]) == 8'h00;
    end
  end

  // Walk from the top down so the lowest matching index is the last written.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// picorv32 native-port bus decoder/mux with access FSM, ready timeout and
// sticky bus-error capture. Optional app-mode fencing: MEM_BUS_APP_FENCE_EN.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                   NUM_SLV        = 8,
  parameter logic [8*NUM_SLV-1:0] SLV_PREFIX     = {NUM_SLV{8'h00}},
  parameter logic [8*NUM_SLV-1:0] SLV_MASK       = {NUM_SLV{8'hff}},
  parameter int                   ADDR_W         = 15,
`ifdef MEM_BUS_APP_FENCE_EN
  parameter logic [NUM_SLV-1:0]   FENCE_MASK     = '0,
`endif
  parameter int                   TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_valid,
  input  logic [3:0]             cpu_wstrb,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic [NUM_SLV-1:0]     slv_cs,
  output logic [3:0]             slv_we,
  output logic [ADDR_W-1:0]      slv_address,
  output logic [31:0]            slv_write_data,
  input  logic [NUM_SLV*32-1:0]  slv_read_data,
  input  logic [NUM_SLV-1:0]     slv_ready,
`ifdef MEM_BUS_APP_FENCE_EN
  input  logic                   fw_app_mode,
`endif
  input  logic                   err_clear,
  output logic                   bus_error,
  output logic [31:0]            err_addr
);

  localparam int         SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  bus_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_hit;
  logic [SEL_W-1:0] cur_sel;
  logic [31:0]      cur_rdata;
  logic             cur_ready;
  logic             fenced;
  logic             cs_en;
  logic             err_set;

  mem_bus_decode #(
    .NUM_SLV    (NUM_SLV),
    .SEL_W      (SEL_W),
    .SLV_PREFIX (SLV_PREFIX),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr_hi (cpu_addr[31:24]),
    .sel     (dec_sel),
    .hit     (dec_hit)
  );

  // In ACCESS the latched selection owns the bus, not the live decode.
  always_comb begin
    cur_sel   = (state_q == ST_ACCESS) ? sel_q : dec_sel;
    cur_rdata = '0;
    cur_ready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        cur_rdata = slv_read_data[32*i +: 32];
        cur_ready = slv_ready[i];
      end
    end
  end

`ifdef MEM_BUS_APP_FENCE_EN
  always_comb begin
    fenced = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dec_sel == SEL_W'(i)) begin
        fenced = fw_app_mode & FENCE_MASK[i];
      end
    end
  end
`else
  assign fenced = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    cs_en   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_valid) begin
          if (!dec_hit || fenced) begin
            rdata_d = '0;
            err_set = 1'b1;
            state_d = ST_RESP;
          end else begin
            cs_en = 1'b1;
            if (cur_ready) begin
              rdata_d = cur_rdata;
              state_d = ST_RESP;
            end else begin
              sel_d   = dec_sel;
              cnt_d   = '0;
              state_d = ST_ACCESS;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (!cpu_valid) begin
          state_d = ST_IDLE;
        end else begin
          cs_en = 1'b1;
          if (cur_ready) begin
            rdata_d = cur_rdata;
            state_d = ST_RESP;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            rdata_d = '0;
            err_set = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_RESP);
  end

  // A clear and a fresh error in the same cycle leave the new error captured.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clear) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (err_set && (!err_q || err_clear)) begin
      err_d      = 1'b1;
      err_addr_d = cpu_addr;
    end
  end

  always_comb begin
    slv_cs = '0;
    if (cs_en && reset_n) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (cur_sel == SEL_W'(i)) begin
          slv_cs[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata      = rdata_q;
  assign cpu_ready      = ready_q;
  assign bus_error      = err_q;
  assign err_addr       = err_addr_q;
  assign slv_we         = cpu_wstrb;
  assign slv_address    = cpu_addr[ADDR_W+1:2];
  assign slv_write_data = cpu_wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios followed by
// randomized accesses against a transaction-level reference model.
module tb_mem_bus_ctrl;

  localparam int          NUM_SLV    = 4;
  localparam int          ADDR_W     = 15;
  localparam int          TIMEOUT    = 4;
  localparam logic [31:0] PREFIX_VEC = {8'h41, 8'hc2, 8'h40, 8'h00};
  localparam logic [31:0] MASK_VEC   = {8'hff, 8'hff, 8'hc0, 8'hc0};

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  cpu_valid;
  logic [3:0]            cpu_wstrb;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic [NUM_SLV-1:0]    slv_cs;
  logic [3:0]            slv_we;
  logic [ADDR_W-1:0]     slv_address;
  logic [31:0]           slv_write_data;
  logic [NUM_SLV*32-1:0] slv_read_data;
  logic [NUM_SLV-1:0]    slv_ready;
  logic                  err_clear;
  logic                  bus_error;
  logic [31:0]           err_addr;

  int checks   = 0;
  int failures = 0;

  // Reference memory map and error-capture state of the model.
  logic [7:0]  ref_prefix [NUM_SLV] = '{8'h00, 8'h40, 8'hc2, 8'h41};
  logic [7:0]  ref_mask   [NUM_SLV] = '{8'hc0, 8'hc0, 8'hff, 8'hff};
  bit          m_err;
  logic [31:0] m_err_addr;

  mem_bus_ctrl #(
    .NUM_SLV        (NUM_SLV),
    .SLV_PREFIX     (PREFIX_VEC),
    .SLV_MASK       (MASK_VEC),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_valid      (cpu_valid),
    .cpu_wstrb      (cpu_wstrb),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ready      (cpu_ready),
    .slv_cs         (slv_cs),
    .slv_we         (slv_we),
    .slv_address    (slv_address),
    .slv_write_data (slv_write_data),
    .slv_read_data  (slv_read_data),
    .slv_ready      (slv_ready),
`ifdef MEM_BUS_APP_FENCE_EN
    .fw_app_mode    (1'b0),
`endif
    .err_clear      (err_clear),
    .bus_error      (bus_error),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NUM_SLV; i++) begin
      if (((a[31:24] ^ ref_prefix[i]) & ref_mask[i]) == 8'h00) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle with no access; optionally pulses err_clear.
  task automatic idleCycle(input bit clr);
    cpu_valid = 1'b0;
    err_clear = clr;
    slv_ready = NUM_SLV'($urandom);
    @(negedge clk);
    checkOutput("idle_ready", 32'(cpu_ready), 32'd0);
    checkOutput("idle_cs", 32'(slv_cs), 32'd0);
    checkOutput("idle_bus_error", 32'(bus_error), 32'(m_err));
    checkOutput("idle_err_addr", err_addr, m_err_addr);
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    if (clr) begin
      m_err      = 1'b0;
      m_err_addr = '0;
    end
  endtask

  // One CPU access; the selected slave raises ready from cycle ready_at on.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input int ready_at,
                               input logic [31:0] rdata, input bit clear_now);
    int                 s;
    int                 done_cyc;
    bit                 acc_err;
    logic [31:0]        exp_rd;
    logic [NUM_SLV-1:0] exp_cs;
    logic [NUM_SLV-1:0] rdy;
    s = ref_decode(addr);
    if (s < 0) begin
      done_cyc = 1;
      acc_err  = 1'b1;
      exp_rd   = '0;
    end else if (ready_at <= TIMEOUT) begin
      done_cyc = ready_at + 1;
      acc_err  = 1'b0;
      exp_rd   = rdata;
    end else begin
      done_cyc = TIMEOUT + 1;
      acc_err  = 1'b1;
      exp_rd   = '0;
    end
    if (clear_now) begin
      m_err      = 1'b0;
      m_err_addr = '0;
    end
    if (acc_err && !m_err) begin
      m_err      = 1'b1;
      m_err_addr = addr;
    end
    slv_read_data = {$urandom, $urandom, $urandom, $urandom};
    if (s >= 0) slv_read_data[32*s +: 32] = rdata;
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    cpu_wstrb = wstrb;
    cpu_wdata = wdata;
    for (int cyc = 0; cyc <= done_cyc; cyc++) begin
      err_clear = clear_now && (cyc == 0);
      rdy = NUM_SLV'($urandom);
      if (s >= 0) rdy[s] = (cyc >= ready_at);
      slv_ready = rdy;
      @(negedge clk);
      exp_cs = '0;
      if (s >= 0 && cyc < done_cyc) exp_cs[s] = 1'b1;
      checkOutput("acc_cs", 32'(slv_cs), 32'(exp_cs));
      checkOutput("acc_ready", 32'(cpu_ready), 32'(cyc == done_cyc));
      if (cyc == 0) begin
        checkOutput("acc_address", 32'(slv_address), 32'(addr[ADDR_W+1:2]));
        checkOutput("acc_we", 32'(slv_we), 32'(wstrb));
        checkOutput("acc_wdata", slv_write_data, wdata);
      end
      if (cyc == done_cyc) begin
        checkOutput("acc_rdata", cpu_rdata, exp_rd);
        checkOutput("acc_bus_error", 32'(bus_error), 32'(m_err));
        checkOutput("acc_err_addr", err_addr, m_err_addr);
      end
      @(posedge clk);
      #1;
    end
    cpu_valid = 1'b0;
    err_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [7:0]  hi;
    reset_n       = 1'b0;
    cpu_valid     = 1'b1;
    cpu_addr      = 32'hc200_0000;
    cpu_wstrb     = 4'h0;
    cpu_wdata     = '0;
    slv_read_data = '0;
    slv_ready     = '1;
    err_clear     = 1'b0;
    m_err         = 1'b0;
    m_err_addr    = '0;

    #2;
    checkOutput("reset_cs", 32'(slv_cs), 32'd0);
    checkOutput("reset_ready", 32'(cpu_ready), 32'd0);
    checkOutput("reset_rdata", cpu_rdata, 32'd0);
    checkOutput("reset_bus_error", 32'(bus_error), 32'd0);
    checkOutput("reset_err_addr", err_addr, 32'd0);
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idleCycle(1'b0);

    $display("[TB] zero-wait read from slave 2");
    applyStimulus(32'hc200_0010, 4'h0, 32'h0, 0, 32'h1234_5678, 1'b0);
    checkOutput("tp_zero_wait_rdata", cpu_rdata, 32'h1234_5678);
    idleCycle(1'b0);

    $display("[TB] wait-state write to slave 1");
    applyStimulus(32'h4000_0100, 4'hf, 32'hdead_beef, 3, 32'h0, 1'b0);

    $display("[TB] unmapped accesses and error capture");
    applyStimulus(32'hc500_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    checkOutput("tp_first_err_addr", err_addr, 32'hc500_0000);
    applyStimulus(32'h8000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    checkOutput("tp_kept_err_addr", err_addr, 32'hc500_0000);
    idleCycle(1'b1);
    idleCycle(1'b0);

    $display("[TB] timeout on slave 0");
    applyStimulus(32'h0000_0040, 4'h0, 32'h0, 99, 32'h5555_aaaa, 1'b0);

    $display("[TB] overlapping prefixes");
    applyStimulus(32'h4100_0000, 4'h3, 32'h0bad_f00d, 1, 32'h0f0f_0f0f, 1'b0);

    $display("[TB] clear and new error in the same cycle");
    applyStimulus(32'h8000_1234, 4'h0, 32'h0, 0, 32'h0, 1'b1);
    checkOutput("tp_same_cycle_err_addr", err_addr, 32'h8000_1234);
    applyStimulus(32'hc200_0020, 4'h0, 32'h0, 0, 32'hcafe_0001, 1'b0);

    $display("[TB] abort by dropping cpu_valid");
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_0080;
    cpu_wstrb = 4'h0;
    slv_ready = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abort_cs_held", 32'(slv_cs), 32'd1);
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_cs_drop", 32'(slv_cs), 32'd0);
    checkOutput("abort_ready0", 32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    idleCycle(1'b0);

    $display("[TB] reset during ACCESS");
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_0100;
    slv_ready = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_cs", 32'(slv_cs), 32'd0);
    checkOutput("rst_mid_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rst_mid_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_mid_bus_error", 32'(bus_error), 32'd0);
    checkOutput("rst_mid_err_addr", err_addr, 32'd0);
    m_err      = 1'b0;
    m_err_addr = '0;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    reset_n   = 1'b1;
    idleCycle(1'b0);
    applyStimulus(32'h4000_0200, 4'h0, 32'h0, 1, 32'h7777_1111, 1'b0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 8))
        0: hi = 8'h00;
        1: hi = 8'h3f;
        2: hi = 8'h40;
        3: hi = 8'h7f;
        4: hi = 8'hc2;
        5: hi = 8'h41;
        6: hi = 8'hc5;
        7: hi = 8'h80;
        default: hi = rnd[31:24];
      endcase
      applyStimulus({hi, rnd[23:0]}, 4'($urandom), $urandom, int'($urandom_range(0, 6)),
                    $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idleCycle(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
